spi_flash_reader: RTL and testbench
===================================

# spi_flash_reader

Sequencer that drives the SPI master's register bus to perform SPI-flash READ (0x03) transactions. It accepts a request (24-bit flash address, byte count), then asserts chip select, shifts out the command and address, and clocks in the data bytes. Read bytes leave on a valid/ready byte stream. It sits between the host-side request logic and the single SPI master, and is that master's only bus client.

## Interface
- `CMD_READ`, default 8'h03: command byte sent first.
- `DUMMY_OUT`, default 8'hFF: byte shifted out while reading data.
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: high only in IDLE.
- `req_addr` in 24: flash byte address.
- `req_len` in 16: number of data bytes to read; 0 means command and address only.
- `abort` in 1: synchronous abort.
- `out_valid` out 1: read byte available.
- `out_ready` in 1: consumer accepts the byte.
- `out_data` out 8: read byte.
- `done` out 1: one-cycle pulse when a transaction ends.
- `aborted` out 1: qualifies `done`; set when the transaction ended through abort.
- `avalid`, `awe` out 1 each; `aaddr` out 1; `adata` out 8: SPI master bus request.
- `bvalid` in 1; `bdata` in 8: SPI master bus response.

## Operation
- SPI master register map:
  - Addr 0 write: bit0 sets the CS level (0 selects the flash).
  - Addr 0 read: bit1 is busy, bit0 is the current CS level.
  - Addr 1 write: loads a byte and starts an 8-bit exchange.
  - Addr 1 read: returns the last received byte.
  - Every access, read or write, is answered by `bvalid` exactly one cycle later.
- At most one bus access is outstanding. `avalid` is a single-cycle pulse. The next access is issued no earlier than the cycle after `bvalid`.
- FSM states: IDLE, CS_LO, TX, POLL, RD, PUSH, CS_HI.
  - IDLE: `req_ready`=1. On `req_valid`, latch `req_addr` and `req_len`, set byte index = 0, go to CS_LO.
  - CS_LO: write addr 0 with 0. On `bvalid`, go to TX.
  - TX: write addr 1. The byte is chosen by the index: index 0 sends `CMD_READ`; indices 1..3 send `addr[23:16]`, `addr[15:8]`, `addr[7:0]`; indices ≥4 send `DUMMY_OUT`. On `bvalid`, go to POLL.
  - POLL: read addr 0. On `bvalid`:
    - `bdata[1]`=1: reissue the poll.
    - Else if index < 4: increment the index. Go to TX if index < 4 or remaining length > 0; otherwise go to CS_HI.
    - Else (index ≥ 4): go to RD.
  - RD: read addr 1. On `bvalid`, capture `bdata` into `out_data` and go to PUSH.
  - PUSH: `out_valid`=1 until `out_ready`. On the accept cycle, decrement the remaining length. Go to TX if the remaining length is still > 0, else CS_HI.
  - CS_HI: write addr 0 with 1. On `bvalid`, pulse `done` and return to IDLE.
- Remaining length is a 16-bit down-counter and never wraps below 0. 65535 is the largest length; 0 skips the data phase.
- Abort, sampled in any state other than IDLE and CS_HI:
  - Wait for any outstanding `bvalid`, without waiting for a pending exchange to finish, then go to CS_HI with `aborted` latched.
  - Abort during PUSH drops `out_valid` the next cycle. An `out_ready` in the same cycle as `abort` still counts as accepted.
- `req_valid` outside IDLE is ignored.

## Timing
- Reset values:
  - `req_ready`=1, `avalid`=0, `awe`=0, `aaddr`=0, `adata`=0.
  - `out_valid`=0, `out_data`=0, `done`=0, `aborted`=0.
  - State is IDLE, counters are 0.
- Reset mid-transaction returns the FSM to IDLE immediately. CS is restored by the SPI master's own reset, since both share `rst_n`.
- Request accepted at cycle 0 → CS_LO `avalid` at cycle 1 → its `bvalid` at cycle 2 → first TX `avalid` at cycle 3.
- Registered outputs only. `out_data` is stable while `out_valid`=1.
- `done` asserts the cycle after the CS_HI `bvalid`. `req_ready` rises in that same cycle.
- Transaction access count with zero busy polls: 2 + 4·2 + len·3 bus accesses.

## Structure
- Shared package `spi_pkg` holds:
  - Register addresses `SPI_REG_CTRL`=0 and `SPI_REG_DATA`=1.
  - Status bit indices `SPI_ST_CS`=0 and `SPI_ST_BUSY`=1.
  - The FSM state enum.
- Natural sub-module: `spi_bus_req`, a one-outstanding-access issuer. It takes start/we/addr/wdata, drives the `a*` pulse, and returns `rdata` plus a done flag when `bvalid` arrives. The FSM instantiates it once.

## Test plan
- Reset released, idle: all outputs at reset values; no `avalid` for 100 cycles.
- Request addr 24'h123456, len 2, with the bench SPI model returning 8'hA5 then 8'h5A:
  - MOSI bytes are 03 12 34 56 FF FF.
  - Stream delivers A5 then 5A.
  - CS goes 0 then 1, and `done` pulses once with `aborted`=0.
- len 0 with addr 24'h000000: exactly four bytes shifted; no `out_valid`; `done` pulses.
- Backpressure: `out_ready` held low 20 cycles during PUSH. `out_data` is stable and no TX access occurs until accept.
- Busy model holds busy for 5 polls per byte: POLL reissues each time, and data is still correct.
- Abort during the data phase of a len-100 transfer: CS written to 1, `done`+`aborted` pulse, `req_ready` returns. Then `rst_n` is pulsed mid-transfer and the FSM returns to IDLE asynchronously.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-flash read sequencer: SPI master register map,
// status bit positions, sequencer state encoding and transmit-byte selection.
package spi_pkg;

    localparam logic       SPI_REG_CTRL = 1'b0;
    localparam logic       SPI_REG_DATA = 1'b1;
    localparam int         SPI_ST_CS    = 0;
    localparam int         SPI_ST_BUSY  = 1;
    localparam logic [2:0] HDR_BYTES    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CS_LO = 3'd1,
        ST_TX    = 3'd2,
        ST_POLL  = 3'd3,
        ST_RD    = 3'd4,
        ST_PUSH  = 3'd5,
        ST_CS_HI = 3'd6
    } rd_state_e;

    // Header is command then address MSB first; everything after is filler.
    function automatic logic [7:0] sel_tx_byte(input logic [2:0]  idx,
                                               input logic [23:0] addr,
                                               input logic [7:0]  cmd,
                                               input logic [7:0]  dummy);
        logic [7:0] b;
        case (idx)
            3'd0:    b = cmd;
            3'd1:    b = addr[23:16];
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            default: b = dummy;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// Register-bus link between the read sequencer and the SPI master:
// single-cycle request pulse out, one-cycle-later response back.
interface spi_flash_reader_if;
    logic       avalid;
    logic       awe;
    logic       aaddr;
    logic [7:0] adata;
    logic       bvalid;
    logic [7:0] bdata;

    modport master (output avalid, awe, aaddr, adata, input bvalid, bdata);
    modport slave  (input avalid, awe, aaddr, adata, output bvalid, bdata);
endinterface

// File: rtl/spi_bus_req.sv
// One-outstanding-access issuer: turns a start strobe into a registered
// request pulse and flags completion when the matching response returns.
module spi_bus_req (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       we_i,
    input  logic       addr_i,
    input  logic [7:0] wdata_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    spi_flash_reader_if.master bus
);

    logic       avalid_q;
    logic       awe_q;
    logic       aaddr_q;
    logic [7:0] adata_q;
    logic       pend_q;

    // Request registers; a new start may coincide with the previous response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avalid_q <= 1'b0;
            awe_q    <= 1'b0;
            aaddr_q  <= 1'b0;
            adata_q  <= 8'h00;
            pend_q   <= 1'b0;
        end else begin
            avalid_q <= start_i;
            if (start_i) begin
                awe_q   <= we_i;
                aaddr_q <= addr_i;
                adata_q <= wdata_i;
                pend_q  <= 1'b1;
            end else if (bus.bvalid) begin
                pend_q  <= 1'b0;
            end
        end
    end

    assign bus.avalid = avalid_q;
    assign bus.awe    = awe_q;
    assign bus.aaddr  = aaddr_q;
    assign bus.adata  = adata_q;
    assign done_o     = bus.bvalid & pend_q;
    assign rdata_o    = bus.bdata;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI-flash READ sequencer: drives the SPI master register bus through
// chip select, command, address and data phases, streaming read bytes out.
module spi_flash_reader
    import spi_pkg::*;
#(
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] DUMMY_OUT = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        done,
    output logic        aborted,
    spi_flash_reader_if.master bus
);

    rd_state_e   state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic [2:0]  idx_q, idx_d;
    logic        req_ready_q;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic        abort_pend_q, abort_pend_d;

    logic        start_s;
    logic        we_s;
    logic        baddr_s;
    logic [7:0]  wdata_s;
    logic        bus_done_s;
    logic [7:0]  bus_rdata_s;
    logic        abort_now_s;
    logic        quit_s;

    spi_bus_req u_bus_req (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_s),
        .we_i    (we_s),
        .addr_i  (baddr_s),
        .wdata_i (wdata_s),
        .done_o  (bus_done_s),
        .rdata_o (bus_rdata_s),
        .bus     (bus)
    );

    // Next-state logic; every entry into an access state issues its access in the same cycle.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        abort_pend_d = abort_pend_q;
        start_s      = 1'b0;

        abort_now_s = abort && (state_q != ST_IDLE) && (state_q != ST_CS_HI);
        quit_s      = abort_now_s || abort_pend_q;
        if (abort_now_s) begin
            abort_pend_d = 1'b1;
        end else begin
            abort_pend_d = abort_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d       = req_addr;
                    len_d        = req_len;
                    idx_d        = 3'd0;
                    abort_pend_d = 1'b0;
                    state_d      = ST_CS_LO;
                    start_s      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CS_LO, ST_TX: begin
                if (bus_done_s) begin
                    start_s = 1'b1;
                    if (quit_s) begin
                        state_d = ST_CS_HI;
                    end else if (state_q == ST_CS_LO) begin
                        state_d = ST_TX;
                    end else begin
                        state_d = ST_POLL;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_POLL: begin
                if (bus_done_s) begin
                    start_s = 1'b1;
                    if (quit_s) begin
                        state_d = ST_CS_HI;
                    end else if (bus_rdata_s[SPI_ST_BUSY]) begin
                        state_d = ST_POLL;
                    end else if (idx_q < HDR_BYTES) begin
                        idx_d = idx_q + 3'd1;
                        if ((idx_d < HDR_BYTES) || (len_q != 16'd0)) begin
                            state_d = ST_TX;
                        end else begin
                            state_d = ST_CS_HI;
                        end
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_POLL;
                end
            end
            ST_RD: begin
                if (bus_done_s) begin
                    if (quit_s) begin
                        state_d = ST_CS_HI;
                        start_s = 1'b1;
                    end else begin
                        out_data_d  = bus_rdata_s;
                        out_valid_d = 1'b1;
                        state_d     = ST_PUSH;
                    end
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_PUSH: begin
                // An accept in the abort cycle still consumes the byte.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (len_q != 16'd0) begin
                        len_d = len_q - 16'd1;
                    end else begin
                        len_d = 16'd0;
                    end
                end else begin
                    len_d = len_q;
                end
                if (quit_s) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_CS_HI;
                    start_s     = 1'b1;
                end else if (out_ready) begin
                    start_s = 1'b1;
                    if (len_d != 16'd0) begin
                        state_d = ST_TX;
                    end else begin
                        state_d = ST_CS_HI;
                    end
                end else begin
                    state_d = ST_PUSH;
                end
            end
            ST_CS_HI: begin
                if (bus_done_s) begin
                    done_d       = 1'b1;
                    aborted_d    = abort_pend_q;
                    abort_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_CS_HI;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus command implied by the state being entered.
    always_comb begin
        we_s    = 1'b1;
        baddr_s = SPI_REG_CTRL;
        wdata_s = 8'h00;
        case (state_d)
            ST_CS_LO: begin
                we_s    = 1'b1;
                baddr_s = SPI_REG_CTRL;
            end
            ST_TX: begin
                we_s    = 1'b1;
                baddr_s = SPI_REG_DATA;
                wdata_s = sel_tx_byte(idx_d, addr_d, CMD_READ, DUMMY_OUT);
            end
            ST_POLL: begin
                we_s    = 1'b0;
                baddr_s = SPI_REG_CTRL;
            end
            ST_RD: begin
                we_s    = 1'b0;
                baddr_s = SPI_REG_DATA;
            end
            ST_CS_HI: begin
                we_s               = 1'b1;
                baddr_s            = SPI_REG_CTRL;
                wdata_s[SPI_ST_CS] = 1'b1;
            end
            default: begin
                we_s = 1'b1;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 24'h000000;
            len_q        <= 16'd0;
            idx_q        <= 3'd0;
            req_ready_q  <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            req_ready_q  <= (state_d == ST_IDLE);
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomized bench for spi_flash_reader: a behavioural SPI master with
// configurable busy time answers the bus; transactions are scored against spec rules.
module tb_spi_flash_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        done;
    logic        aborted;

    spi_flash_reader_if bus_if ();

    spi_flash_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done),
        .aborted   (aborted),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Model state, written only by the responder process.
    logic [7:0] mosi_q[$];
    logic [7:0] stream_q[$];
    logic       cs_log_q[$];
    int access_cnt = 0, proto_err = 0, push_err = 0, stab_err = 0;
    int done_cnt = 0, abt_cnt = 0, hold_cnt = 0;
    logic       pend_v = 1'b0, prev_v = 1'b0, prev_acc = 1'b0, cs_lvl = 1'b1;
    logic [7:0] pend_d = 8'h00, prev_d = 8'h00, rx_last = 8'h00;
    int         busy_left = 0;

    // Configuration, written only by the stimulus process.
    logic [7:0] miso_arr [0:127];
    logic [7:0] data_arr [0:127];
    int busy_cfg = 0, ready_mode = 0, mosi_base = 0;

    // SPI master register model plus stream consumer, evaluated on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_v = 1'b0; bus_if.bvalid = 1'b0; bus_if.bdata = 8'h00;
            cs_lvl = 1'b1; busy_left = 0; out_ready = 1'b0;
            prev_v = 1'b0; prev_acc = 1'b0; hold_cnt = 0;
        end else begin
            bus_if.bvalid = pend_v;
            bus_if.bdata  = pend_v ? pend_d : 8'h00;
            if (bus_if.avalid) begin
                if (pend_v) proto_err++;
                if (out_valid) push_err++;
                access_cnt++;
                pend_d = 8'h00;
                if (bus_if.awe && !bus_if.aaddr) begin
                    cs_lvl = bus_if.adata[0];
                    cs_log_q.push_back(cs_lvl);
                end else if (bus_if.awe) begin
                    int xi;
                    mosi_q.push_back(bus_if.adata);
                    xi = mosi_q.size() - 1 - mosi_base;
                    rx_last = miso_arr[xi[6:0]];
                    busy_left = busy_cfg;
                end else if (!bus_if.aaddr) begin
                    pend_d = {6'd0, (busy_left > 0), cs_lvl};
                    if (busy_left > 0) busy_left--;
                end else begin
                    pend_d = rx_last;
                end
                pend_v = 1'b1;
            end else begin
                pend_v = 1'b0;
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = out_valid && (hold_cnt >= 20);
                default: out_ready = 1'b0;
            endcase
            if (out_valid && prev_v && !prev_acc && (out_data !== prev_d)) stab_err++;
            prev_acc = out_valid && out_ready;
            if (prev_acc) begin
                stream_q.push_back(out_data);
                hold_cnt = 0;
            end else if (out_valid) begin
                hold_cnt++;
            end
            prev_v = out_valid;
            prev_d = out_data;
            if (done) begin
                done_cnt++;
                if (aborted) abt_cnt++;
            end
        end
    end

    logic [23:0] cur_addr;
    int cur_len, cur_busy;
    int stream_base, cs_base, done_base, abt_base, acc_base, proto_base, push_base, stab_base;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_txn(input logic [23:0] a, input int len, input int busy, input int mode,
                             input bit rand_data);
        cur_addr = a; cur_len = len; cur_busy = busy;
        for (int i = 0; i < 128; i++) begin
            if (rand_data) data_arr[i] = 8'($urandom);
        end
        for (int i = 0; i < 128; i++) begin
            miso_arr[i] = (i < 4) ? 8'($urandom) : data_arr[(i - 4) % 128];
        end
        mosi_base = mosi_q.size(); stream_base = stream_q.size(); cs_base = cs_log_q.size();
        done_base = done_cnt; abt_base = abt_cnt; acc_base = access_cnt;
        proto_base = proto_err; push_base = push_err; stab_base = stab_err;
        busy_cfg = busy; ready_mode = mode;
        req_addr = a; req_len = 16'(len); req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 6000; k++) begin
            step();
            if (done_cnt != done_base) break;
        end
        check({tag, "/done_seen"}, (k < 6000) ? 1 : 0, 1);
        check({tag, "/ready_with_done"}, {done, req_ready}, 2'b11);
        step();
        check({tag, "/done_one_cycle"}, done, 1'b0);
    endtask

    task automatic check_txn(input string tag, input bit was_abort);
        logic [7:0] exp_q[$];
        int nm, ns, nc;
        exp_q = {8'h03, cur_addr[23:16], cur_addr[15:8], cur_addr[7:0]};
        repeat (cur_len) exp_q.push_back(8'hFF);
        nm = mosi_q.size() - mosi_base;
        ns = stream_q.size() - stream_base;
        nc = cs_log_q.size() - cs_base;
        if (!was_abort) begin
            check({tag, "/mosi_cnt"}, nm, exp_q.size());
            check({tag, "/stream_cnt"}, ns, cur_len);
            check({tag, "/access_cnt"}, access_cnt - acc_base,
                  2 + 8 + 3 * cur_len + cur_busy * (4 + cur_len));
            check({tag, "/cs_writes"}, nc, 2);
        end
        for (int i = 0; i < nm && i < exp_q.size(); i++)
            check({tag, "/mosi"}, mosi_q[mosi_base + i], exp_q[i]);
        for (int i = 0; i < ns && i < 128; i++)
            check({tag, "/stream"}, stream_q[stream_base + i], data_arr[i]);
        if (nc >= 1) check({tag, "/cs_first"}, cs_log_q[cs_base], 1'b0);
        if (nc >= 2) check({tag, "/cs_last"}, cs_log_q[cs_log_q.size() - 1], 1'b1);
        check({tag, "/done_cnt"}, done_cnt - done_base, 1);
        check({tag, "/aborted_cnt"}, abt_cnt - abt_base, was_abort ? 1 : 0);
        check({tag, "/one_outstanding"}, proto_err - proto_base, 0);
        check({tag, "/no_access_in_push"}, push_err - push_base, 0);
        check({tag, "/data_stable"}, stab_err - stab_base, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, k;
        rst_n = 1'b0; req_valid = 1'b0; abort = 1'b0; req_addr = 24'h0; req_len = 16'h0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst/req_ready", req_ready, 1'b1);
        check("rst/avalid", bus_if.avalid, 1'b0);
        check("rst/awe", bus_if.awe, 1'b0);
        check("rst/aaddr", bus_if.aaddr, 1'b0);
        check("rst/adata", bus_if.adata, 8'h00);
        check("rst/out_valid", out_valid, 1'b0);
        check("rst/out_data", out_data, 8'h00);
        check("rst/done", done, 1'b0);
        check("rst/aborted", aborted, 1'b0);
        a0 = access_cnt;
        repeat (100) step();
        check("idle/no_access", access_cnt - a0, 0);

        data_arr[0] = 8'hA5; data_arr[1] = 8'h5A;
        start_txn(24'h123456, 2, 0, 0, 1'b0);
        wait_done("basic");
        check_txn("basic", 1'b0);

        start_txn(24'h000000, 0, 0, 0, 1'b1);
        wait_done("len0");
        check_txn("len0", 1'b0);

        start_txn(24'hABCDEF, 3, 0, 2, 1'b1);
        wait_done("bpress");
        check_txn("bpress", 1'b0);

        start_txn(24'h00FF01, 3, 5, 1, 1'b1);
        wait_done("busy5");
        check_txn("busy5", 1'b0);

        for (int t = 0; t < 6; t++) begin
            start_txn(24'($urandom), $urandom_range(0, 6), $urandom_range(0, 3),
                      $urandom_range(0, 2), 1'b1);
            wait_done("rand");
            check_txn("rand", 1'b0);
        end

        // Abort mid data phase with the consumer always ready.
        start_txn(24'h400000, 100, 0, 0, 1'b1);
        for (k = 0; k < 3000 && (stream_q.size() - stream_base) < 3; k++) step();
        check("abort_data/reached_data", (k < 3000) ? 1 : 0, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done("abort_data");
        check_txn("abort_data", 1'b1);
        check("abort_data/short", ((stream_q.size() - stream_base) < 100) ? 1 : 0, 1);

        // Abort while a byte waits for a consumer that never accepts.
        start_txn(24'h000010, 10, 1, 3, 1'b1);
        for (k = 0; k < 3000 && !out_valid; k++) step();
        check("abort_push/valid_seen", out_valid, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_push/valid_drop", out_valid, 1'b0);
        wait_done("abort_push");
        check_txn("abort_push", 1'b1);
        check("abort_push/no_bytes", stream_q.size() - stream_base, 0);

        start_txn(24'h0A0B0C, 1, 0, 0, 1'b1);
        wait_done("after_abort");
        check_txn("after_abort", 1'b0);

        // Asynchronous reset in the middle of a long transfer.
        start_txn(24'h777777, 100, 0, 0, 1'b1);
        repeat (40) step();
        check("rstmid/busy_before", req_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid/req_ready", req_ready, 1'b1);
        check("rstmid/avalid", bus_if.avalid, 1'b0);
        check("rstmid/out_valid", out_valid, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        a0 = access_cnt;
        repeat (5) step();
        check("rstmid/quiet", access_cnt - a0, 0);
        start_txn(24'h13579B, 2, 2, 1, 1'b1);
        wait_done("after_rst");
        check_txn("after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
